// File: rtl/multi_reg_processor.sv
// multi_reg_processor: parametrised multi-register processor with an 8-op ALU, Z/N/C flags and a busy/done handshake
// Ports: clk, reset (sync, active-high), run/INSTRin (instruction request, sampled in FETCH),
//        done (last-cycle pulse), busy (not in FETCH), regs_out (r0 in LSBs), a_out, r_out, flags_out {Z,N,C}.
// Build option: define PROC_MULT_EN to include the multiplier; otherwise opcode 011 is a 2-cycle no-op.
module multi_reg_processor #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         run,
    input  logic [DATA_W-1:0]            INSTRin,
    output logic                         done,
    output logic                         busy,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic [DATA_W-1:0]            a_out,
    output logic [DATA_W-1:0]            r_out,
    output logic [2:0]                   flags_out
);
    localparam int RW    = $clog2(NUM_REGS);
    localparam int IMM_W = DATA_W - 4 - RW;
`ifdef PROC_MULT_EN
    localparam bit MULT_EN = 1'b1;
`else
    localparam bit MULT_EN = 1'b0;
`endif
    typedef enum logic [1:0] {FETCH, DECODE, EXEC, WB} state_t;
    typedef enum logic [2:0] {OP_MV, OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_CMP} op_t;
    state_t                            state_q, state_d;
    logic [DATA_W-1:0]                 ir_q, ir_d, a_q, a_d, r_q, r_d;
    logic [2:0]                        flags_q, flags_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]   regs_q;
    op_t                               op;
    logic                              m;
    logic [RW-1:0]                     rx, ry;
    logic [IMM_W-1:0]                  imm;
    logic [DATA_W-1:0]                 operand, mux_out, alu_res;
    logic                              alu_c, wr_en, noop_mul;
    logic [DATA_W:0]                   add_full, sub_full;
    logic [2*DATA_W-1:0]               mul_full;

    assign op       = op_t'(ir_q[DATA_W-1 -: 3]);
    assign m        = ir_q[DATA_W-4];
    assign rx       = ir_q[DATA_W-5 -: RW];
    assign ry       = ir_q[RW-1:0];
    assign imm      = ir_q[IMM_W-1:0];
    assign operand  = m ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm} : regs_q[ry];
    assign noop_mul = (op == OP_MUL) && !MULT_EN;
    // One mux feeds both the register write port and the A load: the operand for mv,
    // rX for the DECODE A-load, and R for write-back.
    assign mux_out  = (state_q == DECODE) ? ((op == OP_MV) ? operand : regs_q[rx]) : r_q;

    assign add_full = {1'b0, a_q} + {1'b0, operand};
    // The extra MSB of a zero-extended subtraction is the borrow (A < operand).
    assign sub_full = {1'b0, a_q} - {1'b0, operand};
`ifdef PROC_MULT_EN
    assign mul_full = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, operand};
`else
    assign mul_full = '0;
`endif

    always_comb begin
        alu_res = a_q & operand;
        alu_c   = 1'b0;
        case (op)
            OP_ADD:         {alu_c, alu_res} = add_full;
            OP_SUB, OP_CMP: {alu_c, alu_res} = sub_full;
            OP_MUL: begin
                alu_res = mul_full[DATA_W-1:0];
                alu_c   = |mul_full[2*DATA_W-1:DATA_W];
            end
            OP_OR:          alu_res = a_q | operand;
            OP_XOR:         alu_res = a_q ^ operand;
            default:        alu_res = a_q & operand;
        endcase
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        a_d     = a_q;
        r_d     = r_q;
        flags_d = flags_q;
        done    = 1'b0;
        wr_en   = 1'b0;
        case (state_q)
            FETCH: if (run) begin
                ir_d    = INSTRin;
                state_d = DECODE;
            end
            DECODE: if (op == OP_MV || noop_mul) begin
                wr_en   = (op == OP_MV);
                done    = 1'b1;
                state_d = FETCH;
            end else begin
                a_d     = mux_out;
                state_d = EXEC;
            end
            EXEC: begin
                r_d     = alu_res;
                flags_d = {alu_res == '0, alu_res[DATA_W-1], alu_c};
                done    = (op == OP_CMP);
                state_d = (op == OP_CMP) ? FETCH : WB;
            end
            WB: begin
                wr_en   = 1'b1;
                done    = 1'b1;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
        if (reset) done = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            ir_q    <= '0;
            a_q     <= '0;
            r_q     <= '0;
            flags_q <= '0;
            regs_q  <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            r_q     <= r_d;
            flags_q <= flags_d;
            if (wr_en) regs_q[rx] <= mux_out;
        end
    end

    assign busy      = (state_q != FETCH);
    assign regs_out  = regs_q;
    assign a_out     = a_q;
    assign r_out     = r_q;
    assign flags_out = flags_q;
endmodule

// File: tb/tb_multi_reg_processor.sv
// tb_multi_reg_processor: randomized bench with an instruction-level reference model for multi_reg_processor
module tb_multi_reg_processor;
`ifdef PROC_MULT_EN
    localparam bit MULT_EN = 1'b1;
`else
    localparam bit MULT_EN = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset, run;
    logic [15:0] INSTRin;
    logic        done, busy;
    logic [63:0] regs_out;
    logic [15:0] a_out, r_out;
    logic [2:0]  flags_out;

    multi_reg_processor #(.DATA_W(16), .NUM_REGS(4)) dut (
        .clk(clk), .reset(reset), .run(run), .INSTRin(INSTRin),
        .done(done), .busy(busy), .regs_out(regs_out),
        .a_out(a_out), .r_out(r_out), .flags_out(flags_out)
    );

    always #5 clk = ~clk;

    int          total = 0, bad = 0, cyc = 0;
    bit          chk = 1'b0;
    logic [15:0] m_regs [4];
    logic [15:0] exp_a = '0, exp_r = '0;
    logic [2:0]  exp_flags = '0;
    logic        exp_done = 1'b0, exp_busy = 1'b0;
    int          done_at [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic logic [63:0] flat_regs();
        return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        exp_a = '0; exp_r = '0; exp_flags = '0; exp_done = 1'b0; exp_busy = 1'b0;
    endtask

    always @(negedge clk) if (chk) begin
        check("done", done, exp_done);
        check("busy", busy, exp_busy);
        check("regs", regs_out, flat_regs());
        check("a", a_out, exp_a);
        check("r", r_out, exp_r);
        check("flags", flags_out, exp_flags);
        if (done) done_at.push_back(cyc);
    end

    // Issues one instruction starting in a FETCH cycle; rst_at: 0 none, -1 random busy cycle, k>0 that cycle.
    task automatic issue(input logic [15:0] ins, input bit hold, input int rst_at);
        int opc, rx, ry, a, b, res, c, len, ra;
        longint p;
        opc = int'(ins[15:13]);
        rx  = int'(ins[11:10]);
        ry  = int'(ins[1:0]);
        a   = int'(m_regs[rx]);
        b   = ins[12] ? ((int'(ins[9:0]) - (ins[9] ? 1024 : 0)) & 'hFFFF) : int'(m_regs[ry]);
        c   = 0;
        res = 0;
        case (opc)
            0: res = b;
            1: begin res = a + b; c = res >> 16; end
            2, 7: begin res = a - b; c = (a < b) ? 1 : 0; end
            3: begin p = longint'(a) * longint'(b); res = int'(p & 'hFFFF); c = ((p >> 16) != 0) ? 1 : 0; end
            4: res = a & b;
            5: res = a | b;
            default: res = a ^ b;
        endcase
        res = res & 'hFFFF;
        len = (opc == 0 || (opc == 3 && !MULT_EN)) ? 2 : (opc == 7) ? 3 : 4;
        ra  = (rst_at < 0) ? int'($urandom_range(len - 1, 1)) : rst_at;
        run = 1'b1;
        INSTRin = ins;
        for (int k = 1; k <= len; k++) begin
            @(posedge clk); #1;
            if (ra != 0 && k == ra + 1) begin
                model_reset();
                reset = 1'b0;
                run = 1'b0;
                return;
            end
            if (k == 2 && len >= 3) exp_a = a[15:0];
            if (k == 3) begin
                exp_r = res[15:0];
                exp_flags = {res == 0, res[15], c[0]};
            end
            if (k == len && opc != 7 && !(opc == 3 && !MULT_EN)) m_regs[rx] = res[15:0];
            exp_busy = (k < len);
            exp_done = (k == len - 1);
            run = (k < len) ? (hold ? 1'b1 : 1'($urandom)) : 1'b0;
            INSTRin = 16'($urandom);
            if (k == ra) begin
                reset = 1'b1;
                exp_done = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            run = 1'b0;
            INSTRin = 16'($urandom);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int c0;
        logic [15:0] ins;
        reset = 1'b1; run = 1'b0; INSTRin = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk = 1'b1;
        check("rst_busy", busy, 1'b0);
        check("rst_regs", regs_out, 64'h0);
        check("rst_flags", flags_out, 3'b000);
        reset = 1'b0;
        idle(2);
        done_at.delete();
        c0 = cyc;
        issue(16'h1BFB, 1'b0, 0);
        check("t1_r2", regs_out[47:32], 16'hFFFB);
        check("t1_flags", flags_out, 3'b000);
        check("t1_done_cnt", done_at.size(), 1);
        check("t1_done_cyc", done_at[0] - c0, 1);
        issue(16'h3807, 1'b0, 0);
        check("t2_a", a_out, 16'hFFFB);
        check("t2_r", r_out, 16'h0002);
        check("t2_r2", regs_out[47:32], 16'h0002);
        check("t2_flags", flags_out, 3'b001);
        issue(16'hF000, 1'b0, 0);
        check("t3_flags", flags_out, 3'b100);
        check("t3_regs", regs_out, 64'h0000_0002_0000_0000);
        issue(16'h1D00, 1'b0, 0);
        done_at.delete();
        c0 = cyc;
        issue(16'h6C03, 1'b0, 0);
`ifdef PROC_MULT_EN
        check("t4_r3", regs_out[63:48], 16'h0000);
        check("t4_flags", flags_out, 3'b101);
        check("t4_done_cyc", done_at[0] - c0, 3);
`else
        check("t4_r3", regs_out[63:48], 16'h0100);
        check("t4_flags", flags_out, 3'b100);
        check("t4_done_cyc", done_at[0] - c0, 1);
`endif
        issue(16'h3403, 1'b0, 2);
        check("t5_regs", regs_out, 64'h0);
        check("t5_busy", busy, 1'b0);
        check("t5_a", a_out, 16'h0000);
        idle(1);
        done_at.delete();
        c0 = cyc;
        issue(16'h1409, 1'b1, 0);
        issue(16'hC401, 1'b1, 0);
        issue(16'h5401, 1'b1, 0);
        check("t6_r1", regs_out[31:16], 16'hFFFF);
        check("t6_flags", flags_out, 3'b011);
        check("t6_done_cnt", done_at.size(), 3);
        check("t6_done0", done_at[0] - c0, 1);
        check("t6_done1", done_at[1] - c0, 5);
        check("t6_done2", done_at[2] - c0, 9);
        for (int n = 0; n < 400; n++) begin
            ins = 16'($urandom);
            issue(ins, 1'($urandom), ($urandom_range(0, 24) == 0) ? -1 : 0);
            if ($urandom_range(0, 5) == 0) idle(int'($urandom_range(1, 3)));
        end
        chk = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
